// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer mix scheduler: default sizes, FSM states, width helpers.
package eq_pkg;
  localparam int NBANDS_DEF = 7;
  localparam int DW_DEF     = 18;
  localparam int WW_DEF     = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_MAC     = 3'd2,
    S_FINAL   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Sum of NBANDS products of (WW+1)-bit by DW-bit signed values never wraps at this width.
  function automatic int acc_width(input int dw, input int ww, input int nb);
    return dw + ww + 1 + $clog2(nb);
  endfunction

  function automatic int w_max(input int ww);
    return (1 << ww) - 1;
  endfunction
endpackage

// File: rtl/eq_weight_bank.sv
// Band-weight registers: rising-edge detect on fup/fdown, per-band saturating up/down counters.
module eq_weight_bank
  import eq_pkg::*;
#(
  parameter int NBANDS = NBANDS_DEF,
  parameter int WW     = WW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NBANDS-1:0]    i_sel,
  input  logic                 i_fup,
  input  logic                 i_fdown,
  output logic [NBANDS*WW-1:0] o_weights
);
  localparam logic [WW-1:0] WMAX = WW'(w_max(WW));

  logic r_up_q, r_dn_q;
  logic w_up, w_dn;

  assign w_up = i_fup & ~r_up_q;
  assign w_dn = i_fdown & ~r_dn_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_up_q <= 1'b0;
      r_dn_q <= 1'b0;
    end else begin
      r_up_q <= i_fup;
      r_dn_q <= i_fdown;
    end
  end

  // Simultaneous up and down edges cancel; both directions saturate.
  for (genvar i = 0; i < NBANDS; i++) begin : g_band
    logic [WW-1:0] r_w;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        r_w <= '0;
      else if (i_sel[i] && w_up && !w_dn && r_w != WMAX)
        r_w <= r_w + 1'b1;
      else if (i_sel[i] && w_dn && !w_up && r_w != '0)
        r_w <= r_w - 1'b1;
    end
    assign o_weights[i*WW +: WW] = r_w;
  end
endmodule

// File: rtl/eq_mac_scheduler.sv
// Per-sample equalizer mixer: snapshots bands/weights on ready, time-shares one multiplier.
// Define EQ_SCHED_SATURATE_EN to clamp the mixed sample instead of wrapping it.
module eq_mac_scheduler
  import eq_pkg::*;
#(
  parameter int NBANDS = NBANDS_DEF,
  parameter int DW     = DW_DEF,
  parameter int WW     = WW_DEF,
  parameter int SHIFT  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ready,
  input  logic [DW-1:0]        audio_allpass,
  input  logic [NBANDS*DW-1:0] band_bus,
  input  logic [9:0]           controls,
  output logic [DW-1:0]        audio_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic [NBANDS*WW-1:0] weights,
  output logic                 overrun
);
  localparam int ACC_W = acc_width(DW, WW, NBANDS);
  localparam int PW    = DW + WW + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam int IW    = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] OUT_MIN = -OUT_MAX - 1;

  state_t                          r_state, w_next;
  logic        [IW-1:0]            r_idx;
  logic signed [DW-1:0]            r_ap;
  logic        [NBANDS-1:0][DW-1:0] r_band;
  logic        [NBANDS-1:0][WW-1:0] r_wsnap;
  logic signed [ACC_W-1:0]         r_acc;
  logic        [DW-1:0]            r_out;
  logic                            r_overrun;
  logic signed [PW-1:0]            w_prod;
  logic signed [SUM_W-1:0]         w_sum;
  logic        [DW-1:0]            w_res;

  eq_weight_bank #(.NBANDS(NBANDS), .WW(WW)) u_wbank (
    .clock    (clock),
    .reset    (reset),
    .i_sel    (controls[NBANDS-1:0]),
    .i_fup    (controls[8]),
    .i_fdown  (controls[9]),
    .o_weights(weights)
  );

  if (NBANDS < 8) begin : g_sel_unused
    logic w_unused;
    assign w_unused = ^controls[7:NBANDS];
  end

  assign w_prod = $signed({1'b0, r_wsnap[r_idx]}) * $signed(r_band[r_idx]);
  assign w_sum  = SUM_W'(r_ap) + SUM_W'(r_acc >>> SHIFT);

`ifdef EQ_SCHED_SATURATE_EN
  always_comb begin
    w_res = w_sum[DW-1:0];
    if (w_sum > OUT_MAX)      w_res = OUT_MAX[DW-1:0];
    else if (w_sum < OUT_MIN) w_res = OUT_MIN[DW-1:0];
  end
`else
  always_comb begin
    w_res = w_sum[DW-1:0];
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (ready) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_MAC;
      S_MAC:     if (r_idx == IW'(NBANDS - 1)) w_next = S_FINAL;
      S_FINAL:   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_CAPTURE) || (r_state == S_MAC) || (r_state == S_FINAL);
    out_valid = (r_state == S_DONE);
  end

  // Snapshot is taken on the accepting edge so later input/weight changes cannot leak in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ap      <= '0;
      r_band    <= '0;
      r_wsnap   <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_out     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (ready && r_state != S_IDLE) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (ready) begin
          r_ap    <= audio_allpass;
          r_band  <= band_bus;
          r_wsnap <= weights;
        end
        S_CAPTURE: begin
          r_acc <= '0;
          r_idx <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_idx <= r_idx + 1'b1;
        end
        S_FINAL: r_out <= w_res;
        default: ;
      endcase
    end
  end

  assign audio_out = r_out;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_eq_mac_scheduler.sv
// Bench for eq_mac_scheduler: directed steps plus randomized samples against an arithmetic model.
module tb_eq_mac_scheduler;
  localparam int NB = 7;
  localparam int DW = 18;
  localparam int WW = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              ready;
  logic [DW-1:0]     audio_allpass;
  logic [NB*DW-1:0]  band_bus;
  logic [9:0]        controls;
  logic [DW-1:0]     audio_out;
  logic              out_valid, busy, overrun;
  logic [NB*WW-1:0]  weights;

  int nvec = 0;
  int nerr = 0;
  int mw[NB];
  int mband[NB];
  int map;

  eq_mac_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .ready        (ready),
    .audio_allpass(audio_allpass),
    .band_bus     (band_bus),
    .controls     (controls),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .weights      (weights),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NB*WW-1:0] model_weights();
    logic [NB*WW-1:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) f[i*WW +: WW] = WW'(mw[i]);
    return f;
  endfunction

  // Mixed sample from the arithmetic definition, then wrap or clamp to DW bits.
  function automatic longint model_out();
    longint acc, s;
    acc = 0;
    for (int i = 0; i < NB; i++) acc += longint'(mw[i]) * longint'(mband[i]);
    s = longint'(map) + acc;
`ifdef EQ_SCHED_SATURATE_EN
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
`else
    s = s & 64'h3FFFF;
    if (s >= 131072) s -= 262144;
`endif
    return s;
  endfunction

  task automatic press(input logic [7:0] sel, input logic up, input logic dn);
    controls = {dn, up, sel};
    step();
    for (int i = 0; i < NB; i++) begin
      if (sel[i] && up && !dn && mw[i] < 31) mw[i]++;
      if (sel[i] && dn && !up && mw[i] > 0)  mw[i]--;
    end
    controls = '0;
    step();
  endtask

  task automatic drive_inputs();
    audio_allpass = DW'(map);
    for (int i = 0; i < NB; i++) band_bus[i*DW +: DW] = DW'(mband[i]);
  endtask

  task automatic rand_bands();
    map = int'($urandom_range(0, 262143)) - 131072;
    for (int i = 0; i < NB; i++) mband[i] = int'($urandom_range(0, 262143)) - 131072;
  endtask

  // Fires one ready, scrambles the inputs, optionally re-pulses ready at cycle extra_at,
  // and watches a bounded window for out_valid pulses.
  task automatic run_sample(input int extra_at, output int lat, output logic signed [63:0] res,
                            output int pulses);
    drive_inputs();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("busy_after_ready", busy, 1);
    audio_allpass = DW'($urandom);
    for (int i = 0; i < NB; i++) band_bus[i*DW +: DW] = DW'($urandom);
    lat = -1; pulses = 0; res = 0;
    for (int k = 1; k <= 16; k++) begin
      ready = (k == extra_at);
      step();
      ready = 1'b0;
      if (k == extra_at) chk("overrun_set", overrun, 1);
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          res = $signed(audio_out);
        end
      end
    end
  endtask

  initial begin
    int lat, pulses, cnt;
    logic signed [63:0] res;
    for (int i = 0; i < NB; i++) begin mw[i] = 0; mband[i] = 0; end
    map = 0;
    reset = 1'b1; ready = 1'b0; controls = '0; audio_allpass = '0; band_bus = '0;
    step(); step();
    chk("rst_audio_out", audio_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_weights", weights, 0);
    reset = 1'b0;
    step();

    // Full sample with ready re-pulsed mid-sequence, then reset aborts the next one.
    press(8'h7F, 1'b1, 1'b0);
    press(8'h7F, 1'b1, 1'b0);
    chk("weights_all2", weights, model_weights());
    rand_bands();
    run_sample(3, lat, res, pulses);
    chk("ovr_latency", lat, 9);
    chk("ovr_pulses", pulses, 1);
    chk("ovr_result", res, model_out());
    chk("ovr_sticky", overrun, 1);
    rand_bands();
    drive_inputs();
    ready = 1'b1; step(); ready = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    #1;
    chk("abort_audio_out", audio_out, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_weights", weights, 0);
    for (int i = 0; i < NB; i++) mw[i] = 0;
    step();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (out_valid) cnt++;
    end
    chk("abort_no_valid", cnt, 0);

    // Zero weights: output is the allpass sample alone.
    rand_bands();
    map = 1000;
    run_sample(0, lat, res, pulses);
    chk("w0_latency", lat, 9);
    chk("w0_result", res, 1000);

    // Three up edges on band 0.
    for (int n = 0; n < 3; n++) press(8'h01, 1'b1, 1'b0);
    chk("w0_eq3", weights[WW-1:0], 3);
    map = 0;
    for (int i = 0; i < NB; i++) mband[i] = 0;
    mband[0] = 100;
    run_sample(0, lat, res, pulses);
    chk("w3_result", res, 300);
    chk("w3_model", res, model_out());

    // Allpass near full scale pushes the sum out of range.
    press(8'h01, 1'b1, 1'b0);
    press(8'h01, 1'b1, 1'b0);
    chk("w0_eq5", weights[WW-1:0], 5);
    map = 131071;
    mband[0] = 1000;
    run_sample(0, lat, res, pulses);
`ifdef EQ_SCHED_SATURATE_EN
    chk("range_result", res, 131071);
`else
    chk("range_result", res, -126073);
`endif

    // Saturation and cancellation of the weight counters.
    for (int n = 0; n < 32; n++) press(8'h02, 1'b1, 1'b0);
    chk("w1_sat_hi", weights[2*WW-1:WW], 31);
    press(8'h02, 1'b1, 1'b1);
    chk("w1_both", weights[2*WW-1:WW], 31);
    press(8'h01, 1'b1, 1'b1);
    chk("w0_both", weights[WW-1:0], 5);
    press(8'h04, 1'b0, 1'b1);
    chk("w2_sat_lo", weights[3*WW-1:2*WW], 0);
    press(8'h80, 1'b1, 1'b0);
    chk("sel7_ignored", weights, model_weights());
    press(8'h01, 1'b0, 1'b1);
    chk("w0_down", weights[WW-1:0], 4);

    // Randomized weights and samples.
    for (int t = 0; t < 12; t++) begin
      for (int p = 0; p < 3; p++)
        press(8'($urandom), 1'($urandom), 1'($urandom));
      chk("rnd_weights", weights, model_weights());
      rand_bands();
      run_sample(0, lat, res, pulses);
      chk("rnd_latency", lat, 9);
      chk("rnd_result", res, model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
